// File: rtl/filter_pkg.sv
// Shared constants, state encoding and settle-time lookup for the filter controller.
package filter_pkg;

  localparam logic [2:0] SEL_BYPASS = 3'b000;
  localparam logic [2:0] SEL_2TAP   = 3'b001;
  localparam logic [2:0] SEL_4TAP   = 3'b010;
  localparam logic [2:0] SEL_8TAP   = 3'b011;
  localparam logic [2:0] SEL_16TAP  = 3'b100;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Cycles the averaging filter needs after a clear before its output is settled.
  function automatic logic [4:0] settle_cycles(input logic [2:0] sel);
    logic [4:0] cycles;
    case (sel)
      SEL_BYPASS: cycles = 5'd2;
      SEL_2TAP:   cycles = 5'd3;
      SEL_4TAP:   cycles = 5'd5;
      SEL_8TAP:   cycles = 5'd9;
      default:    cycles = 5'd17;
    endcase
    return cycles;
  endfunction

  // Codes 4..7 all mean the 16-tap filter.
  function automatic logic [2:0] norm_sel(input logic [2:0] sel);
    logic [2:0] res;
    if (sel[2]) begin
      res = SEL_16TAP;
    end else begin
      res = sel;
    end
    return res;
  endfunction

endpackage

// File: rtl/filter_settle_timer.sv
// Loadable, non-wrapping 5-bit down-counter shared by the FLUSH and FILL phases.
module filter_settle_timer
  import filter_pkg::*;
#(
  parameter logic [4:0] RST_VAL = 5'd1
) (
  input  logic       i_clk,
  input  logic       i_sclr,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  output logic       o_done
);

  logic [4:0] r_cnt;

  // Count holds the cycles remaining in the current phase, including this one.
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 5'd0) begin
      r_cnt <= r_cnt - 5'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt <= 5'd1);

endmodule

// File: rtl/filter_ctrl.sv
// Sequences flush/fill/run of an averaging filter around select changes.
// Optional macro FILTER_CTRL_HOLD_EN: hold the last RUN output during FLUSH/FILL instead of zero.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int BIT_WIDTH    = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        sclr,
  input  logic [2:0]                  sel_req,
  input  logic                        sel_req_valid,
  output logic                        sel_req_ready,
  output logic [2:0]                  filt_sel,
  output logic                        filt_sclr,
  input  logic signed [BIT_WIDTH-1:0] q_in,
  output logic signed [BIT_WIDTH-1:0] q_out,
  output logic                        q_valid
);

  localparam logic [4:0] FLUSH_LD = 5'(FLUSH_CYCLES);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [2:0]                  r_filt_sel;
  logic [2:0]                  w_sel_norm;
  logic                        r_filt_sclr;
  logic                        r_q_valid;
  logic                        r_ready;
  logic signed [BIT_WIDTH-1:0] r_q_out;
  logic                        w_accept;
  logic                        w_change;
  logic                        w_tmr_load;
  logic [4:0]                  w_tmr_val;
  logic                        w_tmr_done;

  filter_settle_timer #(
    .RST_VAL (FLUSH_LD)
  ) u_timer (
    .i_clk      (clk),
    .i_sclr     (sclr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Next-state and timer-load decode; ready is only high in RUN.
  always_comb begin
    w_sel_norm  = norm_sel(sel_req);
    w_accept    = sel_req_valid && r_ready;
    w_change    = w_accept && (w_sel_norm != r_filt_sel);
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = FLUSH_LD;
    case (r_state)
      ST_FLUSH: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_FILL;
          w_tmr_load  = 1'b1;
          w_tmr_val   = settle_cycles(r_filt_sel);
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FILL: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_RUN: begin
        if (w_change) begin
          w_state_nxt = ST_FLUSH;
          w_tmr_load  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_FLUSH;
        w_tmr_load  = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state     <= ST_FLUSH;
      r_filt_sel  <= SEL_BYPASS;
      r_filt_sclr <= 1'b1;
      r_q_valid   <= 1'b0;
      r_ready     <= 1'b0;
      r_q_out     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_filt_sel  <= w_change ? w_sel_norm : r_filt_sel;
      r_filt_sclr <= (w_state_nxt == ST_FLUSH);
      r_q_valid   <= (w_state_nxt == ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      if (w_state_nxt == ST_RUN) begin
        r_q_out <= q_in;
      end else begin
`ifdef FILTER_CTRL_HOLD_EN
        r_q_out <= r_q_out;
`else
        r_q_out <= '0;
`endif
      end
    end
  end

  assign sel_req_ready = r_ready;
  assign filt_sel      = r_filt_sel;
  assign filt_sclr     = r_filt_sclr;
  assign q_valid       = r_q_valid;
  assign q_out         = r_q_out;

endmodule

// File: tb/tb_filter_ctrl.sv
// Self-checking bench for filter_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_filter_ctrl;

  localparam int BW = 32;
  localparam int FC = 1;

  logic                 clk;
  logic                 sclr;
  logic [2:0]           sel_req;
  logic                 sel_req_valid;
  logic                 sel_req_ready;
  logic [2:0]           filt_sel;
  logic                 filt_sclr;
  logic signed [BW-1:0] q_in;
  logic signed [BW-1:0] q_out;
  logic                 q_valid;

  int n_chk;
  int n_err;

  // Model: select in use, cycles elapsed since the last restart, expected q_out.
  int          m_sel;
  int          m_t;
  logic [31:0] m_q;
  logic [31:0] hold_exp;

  filter_ctrl #(
    .BIT_WIDTH    (BW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk           (clk),
    .sclr          (sclr),
    .sel_req       (sel_req),
    .sel_req_valid (sel_req_valid),
    .sel_req_ready (sel_req_ready),
    .filt_sel      (filt_sel),
    .filt_sclr     (filt_sclr),
    .q_in          (q_in),
    .q_out         (q_out),
    .q_valid       (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle(input int sel);
    return (1 << sel) + 1;
  endfunction

  function automatic logic exp_valid();
    return (m_t >= FC + settle(m_sel));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [2:0] sr, input logic sv, input logic [31:0] qi);
    int ns;
    sclr          = s;
    sel_req       = sr;
    sel_req_valid = sv;
    q_in          = qi;
    ns = (sr >= 3'd4) ? 4 : int'(sr);
    if (s) begin
      m_sel = 0;
      m_t   = 0;
      m_q   = 32'd0;
    end else begin
      if (sv && exp_valid() && ns != m_sel) begin
        m_sel = ns;
        m_t   = 0;
      end else if (m_t < 1000) begin
        m_t++;
      end
      if (exp_valid()) begin
        m_q = qi;
      end else begin
`ifndef FILTER_CTRL_HOLD_EN
        m_q = 32'd0;
`endif
      end
    end
    @(posedge clk);
    #1;
    check("filt_sel", {29'd0, filt_sel}, 32'(m_sel));
    check("filt_sclr", {31'd0, filt_sclr}, {31'd0, (m_t < FC)});
    check("q_valid", {31'd0, q_valid}, {31'd0, exp_valid()});
    check("sel_req_ready", {31'd0, sel_req_ready}, {31'd0, exp_valid()});
    check("q_out", q_out, m_q);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, 1'b0, $urandom());
  endtask

  // Holds the request until the model says it was taken, with a cycle bound.
  task automatic request(input logic [2:0] sr);
    logic taken;
    taken = 1'b0;
    for (int k = 0; k < 40 && !taken; k++) begin
      taken = exp_valid();
      step(1'b0, sr, 1'b1, $urandom());
    end
    check("req_accept", {31'd0, taken}, 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_sel = 0;
    m_t   = 0;
    m_q   = 32'd0;
`ifdef FILTER_CTRL_HOLD_EN
    hold_exp = 32'h0000_1234;
`else
    hold_exp = 32'd0;
`endif
    sclr = 1'b1;
    sel_req = 3'd0;
    sel_req_valid = 1'b0;
    q_in = '0;

    // Reset for 3 cycles, then bring-up to RUN with bypass select.
    repeat (3) step(1'b1, 3'd0, 1'b0, $urandom());
    idle(5);

    // Select switch to 8-tap and a same-select no-op.
    request(3'd3);
    idle(12);
    request(3'd2);
    idle(7);
    request(3'd2);
    idle(2);

    // Normalisation of codes 4..7.
    request(3'd4);
    idle(19);
    request(3'd6);
    idle(2);
    request(3'd0);
    idle(4);
    request(3'd6);

    // Reset pulsed four cycles into the 17-cycle fill.
    for (int k = 0; k < 30 && m_t != FC + 4; k++) idle(1);
    check("midfill_reached", 32'(m_t), 32'(FC + 4));
    step(1'b1, 3'd0, 1'b0, $urandom());
    idle(6);

    // Output hold across a switch.
    step(1'b0, 3'd0, 1'b0, 32'h0000_1234);
    step(1'b0, 3'd0, 1'b0, 32'h0000_1234);
    request(3'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 3'd0, 1'b0, $urandom());
      check("hold_valid", {31'd0, q_valid}, 32'd0);
      check("hold_q_out", q_out, hold_exp);
    end
    idle(6);

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(63) == 0), 3'($urandom_range(7)),
           ($urandom_range(2) == 0), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
